// File: rtl/eq_pkg.sv
// Shared constants and state encoding for the equalizer sample path.
package eq_pkg;
  localparam int SMPL_W  = 16;
  localparam int HP_TAPS = 1021;
  localparam int Q_DEPTH = 1024;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    READY = 2'd1,
    SEQ   = 2'd2
  } queue_state_t;
endpackage

// File: rtl/dp_ram_sync.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
module dp_ram_sync #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  // No reset on the array or read register so the tools can map this to block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_o <= mem_q[rd_addr_i];
  end
endmodule

// File: rtl/hp_sample_queue.sv
// Circular sample queue feeding the HP FIR: on each new sample (once full) it
// streams the last TAPS samples oldest-first while sequencing is high.
module hp_sample_queue
  import eq_pkg::*;
#(
  parameter int DEPTH = Q_DEPTH,
  parameter int TAPS  = HP_TAPS,
  parameter int WIDTH = SMPL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wrt_smpl,
  input  logic [WIDTH-1:0] new_smpl,
  output logic [WIDTH-1:0] smpl_out,
  output logic             sequencing,
  output logic             overrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TAPS + 1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] LAST_K  = CW'(TAPS - 1);

  queue_state_t     state_q, state_d;
  logic [AW-1:0]    new_ptr_q, new_ptr_d;
  logic [AW-1:0]    old_ptr_q, old_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    fill_cnt_q, fill_cnt_d;
  logic [CW-1:0]    seq_cnt_q, seq_cnt_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] hold_q, hold_d;

  logic             wr_accept;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] ram_rd_data;

  assign wr_accept  = wrt_smpl && (state_q != SEQ);
  assign sequencing = (state_q == SEQ);
  assign overrun    = overrun_q;

  // The write cycle reads old_ptr so its data is ready on the first SEQ cycle;
  // during SEQ rd_ptr runs one address ahead of the sample on smpl_out.
  assign rd_addr = sequencing ? rd_ptr_q : old_ptr_q;

  dp_ram_sync #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_accept),
    .wr_addr_i (new_ptr_q),
    .wr_data_i (new_smpl),
    .rd_addr_i (rd_addr),
    .rd_data_o (ram_rd_data)
  );

  assign hold_d   = sequencing ? ram_rd_data : hold_q;
  assign smpl_out = sequencing ? ram_rd_data : hold_q;

  always_comb begin
    state_d    = state_q;
    new_ptr_d  = new_ptr_q;
    old_ptr_d  = old_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_cnt_d = fill_cnt_q;
    seq_cnt_d  = seq_cnt_q;
    overrun_d  = overrun_q;

    if (wr_accept) begin
      new_ptr_d = new_ptr_q + PTR_ONE;
    end

    unique case (state_q)
      FILL: begin
        if (wrt_smpl) begin
          fill_cnt_d = fill_cnt_q + CNT_ONE;
          if (fill_cnt_q == LAST_K) begin
            state_d   = SEQ;
            seq_cnt_d = '0;
            rd_ptr_d  = old_ptr_q + PTR_ONE;
          end
        end
      end
      READY: begin
        if (wrt_smpl) begin
          state_d   = SEQ;
          seq_cnt_d = '0;
          rd_ptr_d  = old_ptr_q + PTR_ONE;
        end
      end
      SEQ: begin
        if (wrt_smpl) begin
          overrun_d = 1'b1;
        end
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (seq_cnt_q == LAST_K) begin
          state_d   = READY;
          old_ptr_d = old_ptr_q + PTR_ONE;
        end else begin
          seq_cnt_d = seq_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      new_ptr_q  <= '0;
      old_ptr_q  <= '0;
      rd_ptr_q   <= '0;
      fill_cnt_q <= '0;
      seq_cnt_q  <= '0;
      overrun_q  <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      new_ptr_q  <= new_ptr_d;
      old_ptr_q  <= old_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      seq_cnt_q  <= seq_cnt_d;
      overrun_q  <= overrun_d;
      hold_q     <= hold_d;
    end
  end
endmodule

// File: tb/tb_hp_sample_queue.sv
// Directed bench for hp_sample_queue at full size (DEPTH 1024, TAPS 1021).
module tb_hp_sample_queue;
  localparam int TAPS = 1021;

  logic        clk;
  logic        rst_n;
  logic        wrt_smpl;
  logic [15:0] new_smpl;
  logic [15:0] smpl_out;
  logic        sequencing;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  logic [15:0] hist[$];
  logic [15:0] first_v, last_v;

  hp_sample_queue #(
    .DEPTH (1024),
    .TAPS  (TAPS),
    .WIDTH (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wrt_smpl   (wrt_smpl),
    .new_smpl   (new_smpl),
    .smpl_out   (smpl_out),
    .sequencing (sequencing),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller is aligned to a negedge; returns on the negedge after the accepting posedge.
  task automatic wr(input logic [15:0] v);
    wrt_smpl = 1'b1;
    new_smpl = v;
    hist.push_back(v);
    @(negedge clk);
    wrt_smpl = 1'b0;
  endtask

  // Checks a full window against the last TAPS accepted samples; optionally
  // pulses a (to be dropped) write at SEQ cycle inj_at.
  task automatic run_window(input int inj_at, input logic [15:0] inj_val,
                            output logic [15:0] first_o, output logic [15:0] last_o);
    int base;
    base = hist.size() - TAPS;
    first_o = '0;
    last_o  = '0;
    for (int k = 0; k < TAPS; k++) begin
      chk("seq_high", 16'(sequencing), 16'd1);
      chk("window_smpl", smpl_out, hist[base + k]);
      if (k == 0) first_o = smpl_out;
      if (k == TAPS - 1) last_o = smpl_out;
      if (k == inj_at) begin
        wrt_smpl = 1'b1;
        new_smpl = inj_val;
      end
      @(negedge clk);
      wrt_smpl = 1'b0;
    end
    chk("seq_low_after", 16'(sequencing), 16'd0);
    chk("smpl_hold", smpl_out, hist[hist.size() - 1]);
  endtask

  initial begin
    rst_n    = 1'b0;
    wrt_smpl = 1'b0;
    new_smpl = '0;
    repeat (3) @(negedge clk);
    chk("rst_seq", 16'(sequencing), 16'd0);
    chk("rst_smpl", smpl_out, 16'h0000);
    chk("rst_ovr", 16'(overrun), 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: fill 0..1019 without sequencing, 1020 starts the first window
    for (int i = 0; i < 1020; i++) begin
      wr(16'(i));
      chk("fill_no_seq", 16'(sequencing), 16'd0);
    end
    wr(16'd1020);
    run_window(-1, 16'h0, first_v, last_v);
    chk("t1_first", first_v, 16'd0);
    chk("t1_last", last_v, 16'd1020);
    $display("t1 fill window first=%0d last=%0d", first_v, last_v);

    // 2: steady state
    wr(16'd1021);
    run_window(-1, 16'h0, first_v, last_v);
    chk("t2a_first", first_v, 16'd1);
    chk("t2a_last", last_v, 16'd1021);
    $display("t2 window first=%0d last=%0d", first_v, last_v);
    repeat (4) @(negedge clk);
    chk("t2_idle_seq", 16'(sequencing), 16'd0);
    wr(16'd1022);
    run_window(-1, 16'h0, first_v, last_v);
    chk("t2b_first", first_v, 16'd2);
    chk("t2b_last", last_v, 16'd1022);
    chk("t2_no_ovr", 16'(overrun), 16'd0);
    $display("t2 window first=%0d last=%0d", first_v, last_v);

    // 3: write address wraps 1023->0; last window spans addresses 9..1023,0..5
    for (int i = 1023; i < 1030; i++) begin
      wr(16'(i));
      run_window(-1, 16'h0, first_v, last_v);
      $display("t3 window first=%0d last=%0d", first_v, last_v);
    end
    chk("t3_first", first_v, 16'd9);
    chk("t3_last", last_v, 16'd1029);

    // 4: overrun mid-window and on the final SEQ cycle; both samples dropped
    wr(16'd1030);
    run_window(500, 16'h7FFF, first_v, last_v);
    chk("t4_ovr_set", 16'(overrun), 16'd1);
    chk("t4a_last", last_v, 16'd1030);
    $display("t4 overrun window first=%0d last=%0d ovr=%0d", first_v, last_v, overrun);
    wr(16'd1031);
    run_window(TAPS - 1, 16'h1234, first_v, last_v);
    chk("t4b_first", first_v, 16'd11);
    chk("t4b_last", last_v, 16'd1031);
    repeat (3) @(negedge clk);
    chk("t4_final_drop_idle", 16'(sequencing), 16'd0);
    wr(16'd1032);
    run_window(-1, 16'h0, first_v, last_v);
    chk("t4c_first", first_v, 16'd12);
    chk("t4c_last", last_v, 16'd1032);
    chk("t4_ovr_sticky", 16'(overrun), 16'd1);
    $display("t4 window first=%0d last=%0d", first_v, last_v);

    // 5: reset at SEQ cycle 300
    wr(16'd1033);
    for (int k = 0; k < 300; k++) begin
      chk("t5_seq_high", 16'(sequencing), 16'd1);
      @(negedge clk);
    end
    chk("t5_pre_smpl", smpl_out, 16'd313);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_seq", 16'(sequencing), 16'd0);
    chk("t5_rst_smpl", smpl_out, 16'h0000);
    chk("t5_rst_ovr", 16'(overrun), 16'd0);
    $display("t5 reset mid-window seq=%0d smpl=%0d ovr=%0d", sequencing, smpl_out, overrun);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    hist.delete();

    // 5/6: refill with alternating extremes; 1020 writes must not sequence
    for (int i = 0; i < 1020; i++) begin
      wr(i[0] ? 16'h7FFF : 16'h8000);
      chk("t5_refill_no_seq", 16'(sequencing), 16'd0);
    end
    repeat (5) @(negedge clk);
    chk("t5_refill_idle", 16'(sequencing), 16'd0);
    wr(16'h8000);
    run_window(-1, 16'h0, first_v, last_v);
    chk("t6_first", first_v, 16'h8000);
    chk("t6_last", last_v, 16'h8000);
    $display("t6 signed window first=%h last=%h", first_v, last_v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
